softplus_sq_arbiter: RTL and testbench
======================================

// Module: softplus_sq_arbiter
// PURPOSE
//  Shares one combinational softplus_squared unit (16-bit fixed point, piecewise grad*x+offset)
//  between NUM_REQ requesters, e.g. the VAE encoder mu/logvar lanes. Requester arbitration is
//  round-robin, one operand per cycle. Operand and result are registered in a 2-stage pipeline
//  with full valid/ready backpressure. Each result carries the ID of the requester that issued it.
// PARAMETERS
//  NUM_REQ  2   number of requesters (2..8)
//  ID_W     1   result-tag width; must satisfy 2**ID_W >= NUM_REQ
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            asynchronous, active-low reset
//  req_valid  in   NUM_REQ      per-requester operand valid
//  req_data   in   16*NUM_REQ   operand of requester i at [16*i+15:16*i]
//  req_ready  out  NUM_REQ      one-hot grant; handshake on req_valid[i] & req_ready[i]
//  res_valid  out  1            result valid
//  res_data   out  16           softplus_squared(operand)
//  res_id     out  ID_W         index of the originating requester
//  res_ready  in   1            downstream accepts result
//  busy_cnt   out  32           accepted-operand counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async assert, sync release): s1_valid=0, res_valid=0, res_data=0, res_id=0, rr_ptr=0,
//    busy_cnt=0. req_ready is all-zero while rst_n=0.
//  - Pipeline: S1 = op_q/id_q/s1_valid; S2 = res_data/res_id/res_valid.
//    S2 loads softplus_squared(op_q) when s1_valid & (!res_valid | res_ready).
//    s1_adv = !s1_valid | !res_valid | res_ready (S1 can take a new operand).
//  - Latency: operand accepted at edge T -> res_valid=1 after edge T+1 when res_ready stays high.
//    Sustained throughput is 1 result per cycle.
//  - Arbitration: when s1_adv=1, grant the first i with req_valid[i], searching from rr_ptr upward
//    with wrap. At most one req_ready bit is high. req_ready is combinational from req_valid,
//    rr_ptr and s1_adv. req_ready has no combinational path from req_data.
//  - rr_ptr <= (granted_i+1) mod NUM_REQ on each accept. It is unchanged when no accept occurs.
//  - A requester must hold valid and data until it sees ready. The block does not rely on this
//    rule: dropping valid before grant simply removes the request.
//  - Backpressure: while res_valid=1 & res_ready=0, res_data/res_id hold stable. S1 holds its
//    contents. With S1 full, req_ready=0.
//  - Simultaneous S2 drain and S1 fill in one cycle is allowed; no bubble is inserted.
//  - Arithmetic: 16-bit result exactly as the shared unit produces it (wraps on overflow).
//    No extra rounding.
//  - Reset mid-operation flushes both stages. In-flight operands are discarded, not replayed.
//  - NUM_REQ=1 degenerates to a 2-stage register slice: rr_ptr stays at 0.
// CONFIGURATION
//  Macro SOFTPLUS_SQ_ARB_PERF_EN:
//   defined   - busy_cnt increments by 1 on every accepted operand. It wraps at 2**32 and is
//               cleared only by reset.
//   undefined - busy_cnt is tied to 32'd0 and no counter flops are built.
//               Port list is identical in both builds.
// TESTING
//  1 Reset: hold rst_n=0 with req_valid=2'b11 -> req_ready=0, res_valid=0, res_data=0.
//    Release rst_n -> first grant goes to req 0.
//  2 Single op: req0 sends 0x0100 at edge T, res_ready=1 -> after T+1: res_valid=1, res_id=0,
//    res_data == golden softplus_squared(0x0100).
//  3 Fairness: both requesters valid for 8 cycles -> grants alternate 0,1,0,1,... and
//    res_id follows the same sequence.
//  4 Backpressure: res_ready=0 for 5 cycles while streaming -> at most 2 operands accepted.
//    res_data stays stable. Releasing res_ready gives no loss or duplication, and order is kept.
//  5 Mid-op reset: pulse rst_n low for 1 cycle while both stages are full -> res_valid=0
//    immediately. Flushed items never appear. rr_ptr=0 after release.
//  6 PERF_EN build: 10 accepts -> busy_cnt=10. Non-PERF build -> busy_cnt=0 throughout.

Source files
------------

// File: rtl/softplus_sq_arbiter.sv
// Round-robin arbiter sharing one softplus_squared unit across NUM_REQ requesters,
// behind a 2-stage valid/ready pipeline. Optional busy counter: SOFTPLUS_SQ_ARB_PERF_EN.
module softplus_sq_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   res_valid,
  output logic [15:0]            res_data,
  output logic [ID_W-1:0]        res_id,
  input  logic                   res_ready,
  output logic [31:0]            busy_cnt
);

  // Q8.8 piecewise-linear fit of softplus(x)^2: result = (grad*x >>> 8) + offset, wrapping.
  function automatic logic [15:0] softplus_sq(input logic signed [15:0] x);
    logic signed [15:0] grad;
    logic        [15:0] off;
    logic signed [31:0] prod;
    if (x < -16'sd1024) begin
      grad = 16'sd0;
      off  = 16'h0000;
    end else if (x < 16'sd0) begin
      grad = 16'sd30;
      off  = 16'h007B;
    end else if (x < 16'sd512) begin
      grad = 16'sd516;
      off  = 16'h007B;
    end else begin
      grad = 16'sd1024;
      off  = 16'hFC85;
    end
    prod = 32'(grad) * 32'(x);
    return 16'(prod >>> 8) + off;
  endfunction

  logic [15:0]         op_q, op_d, op_sel;
  logic [ID_W-1:0]     id_q, id_d, gnt_idx;
  logic                s1_valid_q, s1_valid_d;
  logic [15:0]         res_data_q, res_data_d;
  logic [ID_W-1:0]     res_id_q, res_id_d;
  logic                res_valid_q, res_valid_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]  grant;
  logic                s1_adv, s2_load, accept;
  int                  idx;

  assign s1_adv  = !s1_valid_q || !res_valid_q || res_ready;
  assign s2_load = s1_valid_q && (!res_valid_q || res_ready);
  assign accept  = |grant;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    op_sel  = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (s1_adv && (grant == '0) && req_valid[idx]) begin
        grant[idx] = 1'b1;
        gnt_idx    = ID_W'(idx);
        op_sel     = req_data[16*idx +: 16];
      end
    end
  end

  // Reset gating lives only on the output so rst_n never feeds a flop's D input.
  assign req_ready = grant & {NUM_REQ{rst_n}};

  always_comb begin
    op_d        = op_q;
    id_d        = id_q;
    s1_valid_d  = s1_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_valid_d = res_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (s2_load) begin
      res_data_d  = softplus_sq(op_q);
      res_id_d    = id_q;
      res_valid_d = 1'b1;
      s1_valid_d  = 1'b0;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
    if (accept) begin
      op_d       = op_sel;
      id_d       = gnt_idx;
      s1_valid_d = 1'b1;
      rr_ptr_d   = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      id_q        <= '0;
      s1_valid_q  <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      op_q        <= op_d;
      id_q        <= id_d;
      s1_valid_q  <= s1_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

`ifdef SOFTPLUS_SQ_ARB_PERF_EN
  logic [31:0] busy_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      busy_cnt_q <= '0;
    else if (accept) busy_cnt_q <= busy_cnt_q + 32'd1;
  end
  assign busy_cnt = busy_cnt_q;
`else
  assign busy_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_softplus_sq_arbiter.sv
// Directed + randomized bench for softplus_sq_arbiter with a transaction-level queue model.
module tb_softplus_sq_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [31:0] req_data;
  logic [1:0]  req_ready;
  logic        res_valid;
  logic [15:0] res_data;
  logic [0:0]  res_id;
  logic        res_ready;
  logic [31:0] busy_cnt;

  softplus_sq_arbiter #(.NUM_REQ(2), .ID_W(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .res_valid(res_valid), .res_data(res_data),
    .res_id(res_id), .res_ready(res_ready), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

`ifdef SOFTPLUS_SQ_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    int          id;
    logic [15:0] d;
    int          e;
  } item_t;

  item_t q[$];
  int    cnt, ptr, exp_busy, last_gnt;
  int    checks = 0;
  int    failures = 0;

  function automatic logic [15:0] golden(input logic [15:0] xin);
    int x, g, o;
    x = int'(signed'(xin));
    if (x < -1024)     begin g = 0;    o = 0;    end
    else if (x < 0)    begin g = 30;   o = 123;  end
    else if (x < 512)  begin g = 516;  o = 123;  end
    else               begin g = 1024; o = -891; end
    return 16'(((g * x) >>> 8) + o);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: called at a negedge, returns at the next negedge.
  task automatic step(input logic [1:0] v, input logic [15:0] d0, input logic [15:0] d1,
                      input logic rr);
    logic       exp_rv, s1v, adv;
    logic [1:0] exp_rdy;
    int         g, i2;
    exp_rv = (q.size() > 0) && (q[0].e < cnt);
    chk("res_valid", {31'd0, res_valid}, {31'd0, exp_rv});
    if (exp_rv) begin
      chk("res_id", {31'd0, res_id}, q[0].id);
      chk("res_data", {16'd0, res_data}, {16'd0, q[0].d});
    end
    chk("busy_cnt", busy_cnt, exp_busy);
    req_valid = v;
    req_data  = {d1, d0};
    res_ready = rr;
    #1;
    s1v = (q.size() == 2) || (q.size() == 1 && q[0].e == cnt);
    adv = !s1v || !exp_rv || rr;
    g = -1;
    if (adv)
      for (int k = 0; k < 2; k++) begin
        i2 = (ptr + k) % 2;
        if (g < 0 && v[i2]) g = i2;
      end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
    last_gnt = g;
    @(posedge clk);
    if (exp_rv && rr) void'(q.pop_front());
    cnt++;
    if (g >= 0) begin
      q.push_back('{id: g, d: golden(g == 1 ? d1 : d0), e: cnt});
      ptr = (g + 1) % 2;
      if (PERF) exp_busy++;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    cnt = 0;
    ptr = 0;
    exp_busy = 0;
  endtask

  initial begin
    logic [15:0] hold_d;
    logic [0:0]  hold_id;
    int          acc, prev;

    // Reset with both requesters asserting valid
    rst_n = 1'b0; req_valid = 2'b11; req_data = '0; res_ready = 1'b1;
    model_reset();
    #12;
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_data", {16'd0, res_data}, 32'd0);
    chk("rst_busy", busy_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step(2'b11, 16'h1234, 16'h5678, 1'b1);
    chk("first_grant", last_gnt, 0);
    for (int i = 0; i < 3; i++) step(2'b00, 16'h0, 16'h0, 1'b1);

    // Single op: 1.0 in Q8.8
    step(2'b01, 16'h0100, 16'h0000, 1'b1);
    step(2'b00, 16'h0000, 16'h0000, 1'b1);
    chk("single_valid", {31'd0, res_valid}, 32'd1);
    chk("single_id", {31'd0, res_id}, 32'd0);
    chk("single_data", {16'd0, res_data}, 32'h027F);
    step(2'b00, 16'h0000, 16'h0000, 1'b1);

    // Fairness and full throughput
    prev = -1;
    for (int i = 0; i < 8; i++) begin
      step(2'b11, 16'($urandom), 16'($urandom), 1'b1);
      chk("fair_accept", {31'd0, last_gnt >= 0}, 32'd1);
      if (prev >= 0) chk("fair_alt", last_gnt, 1 - prev);
      prev = last_gnt;
    end

    // Backpressure while streaming
    hold_d = res_data; hold_id = res_id; acc = 0;
    for (int i = 0; i < 5; i++) begin
      step(2'b11, 16'($urandom), 16'($urandom), 1'b0);
      if (last_gnt >= 0) acc++;
      chk("bp_valid", {31'd0, res_valid}, 32'd1);
      chk("bp_data_hold", {16'd0, res_data}, {16'd0, hold_d});
      chk("bp_id_hold", {31'd0, res_id}, {31'd0, hold_id});
    end
    chk("bp_accepts_le2", {31'd0, acc <= 2}, 32'd1);
    for (int i = 0; i < 4; i++) step(2'b00, 16'h0, 16'h0, 1'b1);
    chk("bp_drained", {31'd0, res_valid}, 32'd0);
    chk("bp_model_empty", q.size(), 32'd0);

    // Mid-op reset with both stages full
    step(2'b10, 16'h0300, 16'h0700, 1'b0);
    step(2'b11, 16'hFF00, 16'h0080, 1'b0);
    step(2'b11, 16'h0001, 16'h0002, 1'b0);
    chk("full_before_rst", q.size(), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("midrst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("midrst_busy", busy_cnt, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(2'b00, 16'h0, 16'h0, 1'b1);

    // Ten accepts after reset; grant restarts at 0
    for (int i = 0; i < 10; i++) begin
      step(2'b11, 16'($urandom), 16'($urandom), 1'b1);
      if (i == 0) chk("post_rst_grant", last_gnt, 0);
    end
    chk("busy_after_10", busy_cnt, PERF ? 32'd10 : 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
           $urandom_range(0, 9) < 7);
    for (int i = 0; i < 4; i++) step(2'b00, 16'h0, 16'h0, 1'b1);
    chk("final_empty", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
